pc_npc_unit: RTL and testbench

Parametrised program-counter unit holding the PC/nPC pair for the fetch stage of the pipelined CPU. It advances sequentially, applies delayed or annulled branch redirects, and holds both registers under a load enable. A redirect that arrives while the unit is held is buffered and applied on the next enabled cycle. It replaces the single fixed-width PC register and feeds instruction-memory addressing and the branch/jump logic.

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_redir_buf.sv | 49 ++++
 rtl/pc_npc_unit.sv | 93 +++++++++
 tb/tb_pc_npc_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the PC/nPC unit
package pc_pkg;

    localparam int PC_WIDTH_DEF = 32;
    localparam int PC_RESET_DEF = 0;
    localparam int PC_INC_DEF   = 4;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_e;

    typedef struct packed {
        logic [PC_WIDTH_DEF-1:0] target;
        logic                    annul;
    } pc_redir_t;

endpackage

// File: rtl/pc_redir_buf.sv
// rtl/pc_redir_buf.sv - buffers a redirect seen during a stall and selects the effective redirect
module pc_redir_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             le,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             redir_annul,
    output logic             o_eff_valid,
    output logic [WIDTH-1:0] o_eff_target,
    output logic             o_eff_annul,
    output logic             o_pend
);

    typedef struct packed {
        logic [WIDTH-1:0] target;
        logic             annul;
    } redir_t;

    pc_state_e r_state;
    redir_t    r_buf;
    logic      w_pend;

    assign w_pend = (r_state == PEND);

    // A live redirect always beats the buffered one.
    assign o_eff_valid  = redir_valid | w_pend;
    assign o_eff_target = redir_valid ? redir_target : r_buf.target;
    assign o_eff_annul  = redir_valid ? redir_annul  : r_buf.annul;
    assign o_pend       = w_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_buf   <= '0;
        end else if (le) begin
            r_state <= RUN;
        end else if (redir_valid) begin
            r_state      <= PEND;
            r_buf.target <= redir_target;
            r_buf.annul  <= redir_annul;
        end
    end

endmodule

// File: rtl/pc_npc_unit.sv
// rtl/pc_npc_unit.sv - PC/nPC register pair with delayed/annulled redirects and stall buffering
// Optional sticky alignment fault output enabled by PC_ALIGN_CHECK_EN.
module pc_npc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = PC_WIDTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(PC_RESET_DEF),
    parameter int unsigned      INC      = PC_INC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             le,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             redir_annul,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic             pend_out
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic             misalign_out
`endif
);

    localparam logic [WIDTH-1:0] W_INC = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_npc;
    logic             w_eff_valid;
    logic [WIDTH-1:0] w_eff_target;
    logic             w_eff_annul;
    logic             w_pend;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_npc_nxt;

    pc_redir_buf #(
        .WIDTH(WIDTH)
    ) u_redir_buf (
        .clk          (clk),
        .reset        (reset),
        .le           (le),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .redir_annul  (redir_annul),
        .o_eff_valid  (w_eff_valid),
        .o_eff_target (w_eff_target),
        .o_eff_annul  (w_eff_annul),
        .o_pend       (w_pend)
    );

    always_comb begin
        w_pc_nxt  = r_npc;
        w_npc_nxt = r_npc + W_INC;
        if (w_eff_valid) begin
            if (w_eff_annul) begin
                w_pc_nxt  = w_eff_target;
                w_npc_nxt = w_eff_target + W_INC;
            end else begin
                w_npc_nxt = w_eff_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_npc <= RESET_PC + W_INC;
        end else if (le) begin
            r_pc  <= w_pc_nxt;
            r_npc <= w_npc_nxt;
        end
    end

    assign pc_out   = r_pc;
    assign npc_out  = r_npc;
    assign pend_out = w_pend;

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    // Sticky: only reset clears it; the misaligned target is still loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (le && w_eff_valid && ((w_eff_target % W_INC) != '0)) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign_out = r_misalign;
`endif

endmodule

// File: tb/tb_pc_npc_unit.sv
// tb/tb_pc_npc_unit.sv - self-checking bench for pc_npc_unit against a behavioural model
module tb_pc_npc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        le;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        redir_annul;
    logic [31:0] pc_out;
    logic [31:0] npc_out;
    logic        pend_out;
    logic        misalign_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_npc, m_pt;
    logic        m_pend, m_pa, m_mis;

    pc_npc_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0),
        .INC      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .le           (le),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .redir_annul  (redir_annul),
        .pc_out       (pc_out),
        .npc_out      (npc_out),
        .pend_out     (pend_out)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .misalign_out (misalign_out)
`endif
    );

`ifndef PC_ALIGN_CHECK_EN
    assign misalign_out = 1'b0;
`endif

    always #5 clk = ~clk;

    // One clock: drive inputs, let the edge happen, advance the model by the stated rules.
    task automatic cyc(input logic rst, input logic l, input logic rv,
                       input logic [31:0] rt, input logic ra);
        logic        have;
        logic [31:0] t;
        logic        a;
        reset = rst; le = l; redir_valid = rv; redir_target = rt; redir_annul = ra;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_npc = 32'h4; m_pend = 1'b0; m_pt = '0; m_pa = 1'b0; m_mis = 1'b0;
        end else if (l) begin
            have = rv || m_pend;
            t    = rv ? rt : m_pt;
            a    = rv ? ra : m_pa;
            if (have && (t % 4 != 0)) m_mis = 1'b1;
            if (!have) begin
                m_pc = m_npc; m_npc = m_npc + 4;
            end else if (!a) begin
                m_pc = m_npc; m_npc = t;
            end else begin
                m_pc = t; m_npc = t + 4;
            end
            m_pend = 1'b0;
        end else if (rv) begin
            m_pend = 1'b1; m_pt = rt; m_pa = ra;
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 32'h1234, 1);
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
        checks++; if (npc_out !== 32'h4) begin errors++; $display("FAIL reset_npc got %h exp %h", npc_out, 32'h4); end
        checks++; if (pend_out !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", pend_out); end
`ifdef PC_ALIGN_CHECK_EN
        checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misalign_out); end
`endif
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            checks++; if (pc_out !== 32'(4*i)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc_out, 32'(4*i)); end
            checks++; if (npc_out !== 32'(4*i+4)) begin errors++; $display("FAIL seq_npc[%0d] got %h exp %h", i, npc_out, 32'(4*i+4)); end
        end
    endtask

    task automatic test_delayed();
        cyc(0, 1, 1, 32'h10, 1);
        checks++; if (pc_out !== 32'h10 || npc_out !== 32'h14) begin errors++; $display("FAIL dly_setup got %h/%h exp 10/14", pc_out, npc_out); end
        cyc(0, 1, 1, 32'h100, 0);
        checks++; if (pc_out !== 32'h14 || npc_out !== 32'h100) begin errors++; $display("FAIL dly_slot got %h/%h exp 14/100", pc_out, npc_out); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (pc_out !== 32'h100 || npc_out !== 32'h104) begin errors++; $display("FAIL dly_taken got %h/%h exp 100/104", pc_out, npc_out); end
    endtask

    task automatic test_annul();
        cyc(0, 1, 1, 32'h10, 1);
        cyc(0, 1, 1, 32'h200, 1);
        checks++; if (pc_out !== 32'h200 || npc_out !== 32'h204) begin errors++; $display("FAIL annul got %h/%h exp 200/204", pc_out, npc_out); end
    endtask

    task automatic test_stall_redirect();
        cyc(0, 0, 1, 32'h300, 0);
        checks++; if (pc_out !== 32'h200 || npc_out !== 32'h204 || pend_out !== 1'b1) begin errors++; $display("FAIL stall1 got %h/%h/%b exp 200/204/1", pc_out, npc_out, pend_out); end
        cyc(0, 0, 1, 32'h400, 1);
        checks++; if (pc_out !== 32'h200 || npc_out !== 32'h204 || pend_out !== 1'b1) begin errors++; $display("FAIL stall2 got %h/%h/%b exp 200/204/1", pc_out, npc_out, pend_out); end
        cyc(0, 0, 0, 0, 0);
        checks++; if (pend_out !== 1'b1) begin errors++; $display("FAIL stall_hold got %b exp 1", pend_out); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (pc_out !== 32'h400 || npc_out !== 32'h404 || pend_out !== 1'b0) begin errors++; $display("FAIL stall_apply got %h/%h/%b exp 400/404/0", pc_out, npc_out, pend_out); end
    endtask

    task automatic test_wrap();
        cyc(0, 1, 1, 32'hFFFF_FFF8, 1);
        cyc(0, 1, 0, 0, 0);
        checks++; if (pc_out !== 32'hFFFF_FFFC || npc_out !== 32'h0) begin errors++; $display("FAIL wrap got %h/%h exp fffffffc/0", pc_out, npc_out); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (pc_out !== 32'h0 || npc_out !== 32'h4) begin errors++; $display("FAIL wrap2 got %h/%h exp 0/4", pc_out, npc_out); end
    endtask

    task automatic test_reset_in_pend();
        cyc(0, 1, 1, 32'h80, 1);
        cyc(0, 0, 1, 32'h500, 1);
        checks++; if (pend_out !== 1'b1) begin errors++; $display("FAIL rp_pend got %b exp 1", pend_out); end
        cyc(1, 0, 0, 0, 0);
        checks++; if (pc_out !== 32'h0 || npc_out !== 32'h4 || pend_out !== 1'b0) begin errors++; $display("FAIL rp_reset got %h/%h/%b exp 0/4/0", pc_out, npc_out, pend_out); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (pc_out !== 32'h4 || npc_out !== 32'h8) begin errors++; $display("FAIL rp_dropped got %h/%h exp 4/8", pc_out, npc_out); end
    endtask

`ifdef PC_ALIGN_CHECK_EN
    task automatic test_misalign();
        cyc(0, 1, 1, 32'h102, 1);
        checks++; if (pc_out !== 32'h102 || misalign_out !== 1'b1) begin errors++; $display("FAIL mis_set got %h/%b exp 102/1", pc_out, misalign_out); end
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h40, 1);
        checks++; if (misalign_out !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b exp 1", misalign_out); end
        cyc(1, 0, 0, 0, 0);
        checks++; if (misalign_out !== 1'b0) begin errors++; $display("FAIL mis_clear got %b exp 0", misalign_out); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            t = $urandom;
            if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
            cyc($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, t, $urandom_range(0, 1) == 1);
            checks++;
            if (pc_out !== m_pc || npc_out !== m_npc || pend_out !== m_pend) begin
                errors++;
                $display("FAIL rand[%0d] got %h/%h/%b exp %h/%h/%b", i, pc_out, npc_out, pend_out, m_pc, m_npc, m_pend);
            end
`ifdef PC_ALIGN_CHECK_EN
            checks++;
            if (misalign_out !== m_mis) begin
                errors++;
                $display("FAIL rand_mis[%0d] got %b exp %b", i, misalign_out, m_mis);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; le = 1'b0; redir_valid = 1'b0; redir_target = '0; redir_annul = 1'b0;
        m_pc = '0; m_npc = 32'h4; m_pend = 1'b0; m_pt = '0; m_pa = 1'b0; m_mis = 1'b0;
        test_reset();
        test_sequential();
        test_delayed();
        test_annul();
        test_stall_redirect();
        test_wrap();
        test_reset_in_pend();
`ifdef PC_ALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
